bu2020_data_memory: RTL and testbench
=====================================

Name: bu2020_data_memory

Overview:
- Data-memory slave on the CPU's MEM-stage bus: address, bidirectional data and write-mode lines.
- Contains a word-addressed RAM below MMIO_BASE.
- Contains a small memory-mapped I/O window at and above MMIO_BASE: a GPIO output register, a synchronised GPIO input and a 16-bit compare timer that raises an interrupt.
- Reads are combinational so the MEM stage captures data at the same clock edge; writes commit at the clock edge.

Parameters:
ADDR_W, 12, width of Memory_addressbus
DATA_W, 16, word width of Memory_databus
MMIO_BASE, 12'hFF0, first MMIO address; RAM covers 0 .. MMIO_BASE-1
INIT_FILE, "", optional $readmemh image for RAM; empty string means no preload

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
Memory_addressbus  input  ADDR_W  word address from MEM stage
Memory_databus  inout  DATA_W  shared data bus: CPU drives on write, block drives on read
Memory_writemode  input  1  1 = write cycle (CPU drives bus), 0 = read cycle
gpio_out  output  16  GPIO output register value
gpio_in  input  16  asynchronous external inputs
timer_irq  output  1  level interrupt, equals timer match flag

Behaviour:
- Reset and clock:
  - One clock (clk). Reset is asynchronous and active-low (rst_n).
  - On rst_n low: gpio_out=0, gpio_in sync flops=0, timer count=0, compare=0, ctrl=0, match flag=0, timer_irq=0.
  - RAM contents are not reset: they hold INIT_FILE contents, or are X without it.
- Bus direction:
  - Block drives Memory_databus only while Memory_writemode=0; otherwise the bus is high-Z.
  - No internal turnaround state; direction follows Memory_writemode combinationally.
- Read (writemode=0):
  - Databus = word at address, combinational, zero added latency.
  - MMIO reads:
    - FF0 gpio_out.
    - FF1 gpio_in after 2-flop synchroniser (2-cycle latency from pin).
    - FF2 count.
    - FF3 compare.
    - FF4 status = {flag,13'b0,autoreload,enable}.
    - FF5..FFF read 0.
- Write (writemode=1):
  - Databus sampled at rising edge and committed there; a read of the same address in the next cycle returns the new value.
  - RAM: mem[addr] <= data.
  - FF0: gpio_out <= data.
  - FF1: ignored.
  - FF2: count <= data.
  - FF3: compare <= data.
  - FF4: enable <= d[0], autoreload <= d[1]; d[15]=1 clears flag (write-1-to-clear).
  - FF5..FFF: ignored.
- Timer, per cycle, when enable=1:
  - If count==compare: flag <= 1; count <= 0 if autoreload, else count+1.
  - Otherwise count <= count+1.
  - Count wraps FFFF -> 0000 silently (modulo 2^16).
  - enable=0 freezes count; no match detection while frozen.
- Simultaneous events:
  - CPU write to FF2 in the same cycle as an increment: the written value wins.
  - Write-1-to-clear in the same cycle as a new match: set wins, flag stays 1.
  - Write to FF4 that sets enable: counting starts the following cycle.
- timer_irq = flag (registered, no combinational path from the bus).
- Reset asserted mid-write: the write is not guaranteed and the RAM word is undefined. MMIO registers are forced to their reset values asynchronously.
- Addresses are compared on the full ADDR_W bits; no aliasing.

Test Plan:
- Reset, then write 0x1234 to 0x005 and 0xBEEF to 0xFEF, then read both -> 0x1234 and 0xBEEF returned in the read cycle. Bus is high-Z during both write cycles.
- Write 0x00A5 to FF0 -> gpio_out=0x00A5 after the edge. Drive gpio_in=0x5A5A -> read FF1 returns 0x5A5A from the 2nd edge onward; the first edge still reads 0. Write to FF1 -> no effect. Reads of FF5/FFF -> 0x0000.
- Compare=5, count=0, write FF4=0x0001 -> timer_irq rises 6 cycles after enabling. Count then continues 6, 7, ... Write FF4=0x8001 -> irq falls next cycle.
- Autoreload: compare=3, write FF4=0x0003 -> count sequence 0,1,2,3,0,1,... and flag set at the first match. Write FF2=0xFFFE with compare=0x0010 and autoreload off -> count wraps FFFF -> 0000.
- Same-cycle corner cases: write FF2=0x0100 while enabled -> next read returns 0x0100, not old+1. Clear flag on the same cycle as a match -> flag remains 1.
- Assert rst_n low mid-run with timer enabled and gpio_out=0xFFFF -> gpio_out=0 and timer_irq=0 immediately, without waiting for a clock edge. RAM word at 0x005 is unaffected by reset when no write was in progress.

Source files
------------

// File: rtl/bu2020_data_memory_if.sv
// MEM-stage address and direction lines from the CPU to the data memory.
// The shared data bus stays a plain inout port of the memory so tri-state resolution happens on a simple net.
`timescale 1ns/1ps
interface bu2020_data_memory_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] Memory_addressbus;
    logic              Memory_writemode;

    modport master (
        output Memory_addressbus,
        output Memory_writemode
    );

    modport slave (
        input Memory_addressbus,
        input Memory_writemode
    );
endinterface

// File: rtl/bu2020_data_memory.sv
// Data memory: word RAM below MMIO_BASE, GPIO and a compare timer above it.
// Latency: reads combinational (0 cycles), writes commit at the rising edge.
// Backpressure: none; every bus cycle completes. Bus is driven only on reads.
`timescale 1ns/1ps
module bu2020_data_memory #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 12'hFF0,
    parameter string             INIT_FILE = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bu2020_data_memory_if.slave     mem_if,
    inout  wire  [DATA_W-1:0]       Memory_databus,
    output logic [15:0]             gpio_out,
    input  logic [15:0]             gpio_in,
    output logic                    timer_irq
);

    localparam int                RAM_DEPTH = int'(MMIO_BASE);
    localparam logic [ADDR_W-1:0] A_GPO = MMIO_BASE;
    localparam logic [ADDR_W-1:0] A_GPI = MMIO_BASE + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CNT = MMIO_BASE + ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CMP = MMIO_BASE + ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STS = MMIO_BASE + ADDR_W'(4);

    logic [DATA_W-1:0] mem [0:RAM_DEPTH-1];

    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              ram_sel;
    logic [DATA_W-1:0] wr_dat;
    logic [15:0]       wr16;
    logic [DATA_W-1:0] rd_dat;
    logic              hit;

    logic [15:0] gpio_out_q, gpio_out_d;
    logic [15:0] sync1_q, sync1_d;
    logic [15:0] sync2_q, sync2_d;
    logic [15:0] count_q, count_d;
    logic [15:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        ar_q, ar_d;
    logic        flag_q, flag_d;

    assign addr    = mem_if.Memory_addressbus;
    assign we      = mem_if.Memory_writemode;
    assign ram_sel = (addr < MMIO_BASE);
    assign wr_dat  = Memory_databus;
    assign wr16    = wr_dat[15:0];

    // Direction follows writemode directly; the CPU owns the bus on writes.
    assign Memory_databus = we ? {DATA_W{1'bz}} : rd_dat;

    always_comb begin
        rd_dat = '0;
        if (ram_sel) begin
            rd_dat = mem[addr];
        end else begin
            case (addr)
                A_GPO:   rd_dat = DATA_W'(gpio_out_q);
                A_GPI:   rd_dat = DATA_W'(sync2_q);
                A_CNT:   rd_dat = DATA_W'(count_q);
                A_CMP:   rd_dat = DATA_W'(cmp_q);
                A_STS:   rd_dat = DATA_W'({flag_q, 13'b0, ar_q, en_q});
                default: rd_dat = '0;
            endcase
        end
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        sync1_d    = gpio_in;
        sync2_d    = sync1_q;
        count_d    = count_q;
        cmp_d      = cmp_q;
        en_d       = en_q;
        ar_d       = ar_q;
        flag_d     = flag_q;
        hit        = en_q && (count_q == cmp_q);

        if (en_q) begin
            count_d = (hit && ar_q) ? 16'd0 : count_q + 16'd1;
        end

        // Bus writes override the timer's own update for the same cycle.
        if (we && !ram_sel) begin
            case (addr)
                A_GPO: gpio_out_d = wr16;
                A_CNT: count_d    = wr16;
                A_CMP: cmp_d      = wr16;
                A_STS: begin
                    en_d = wr16[0];
                    ar_d = wr16[1];
                    if (wr16[15]) begin
                        flag_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // A fresh match beats a same-cycle write-1-to-clear.
        if (hit) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            count_q    <= '0;
            cmp_q      <= '0;
            en_q       <= 1'b0;
            ar_q       <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            en_q       <= en_d;
            ar_q       <= ar_d;
            flag_q     <= flag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we && ram_sel) begin
            mem[addr] <= wr_dat;
        end
    end

    assign gpio_out  = gpio_out_q;
    assign timer_irq = flag_q;

endmodule

// File: tb/tb_bu2020_data_memory.sv
// Bench for bu2020_data_memory: directed scenarios plus a randomized phase,
// all compared against a behavioural model of the memory map and timer.
`timescale 1ns/1ps
module tb_bu2020_data_memory;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bu2020_data_memory_if #(.ADDR_W(12)) mif ();

    wire  [15:0] dbus;
    logic        drv_en;
    logic [15:0] drv_dat;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;
    logic        timer_irq;

    assign dbus = drv_en ? drv_dat : 16'hzzzz;

    bu2020_data_memory #(
        .ADDR_W(12), .DATA_W(16), .MMIO_BASE(12'hFF0), .INIT_FILE("")
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_if         (mif),
        .Memory_databus (dbus),
        .gpio_out       (gpio_out),
        .gpio_in        (gpio_in),
        .timer_irq      (timer_irq)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] ram_m [int];
    logic [15:0] m_gpio, m_cnt, m_cmp;
    logic        m_en, m_ar, m_flag;
    logic [15:0] pin_hist [$];
    logic [15:0] pin_drive;

    // Per-cycle observed / expected values
    logic [15:0] ob, eb, og, eg;
    logic        oi, ei;

    function automatic logic [15:0] model_read(input logic [11:0] a);
        if (a < 12'hFF0) return ram_m.exists(int'(a)) ? ram_m[int'(a)] : 16'h0000;
        case (a)
            12'hFF0: return m_gpio;
            12'hFF1: return pin_hist[1];
            12'hFF2: return m_cnt;
            12'hFF3: return m_cmp;
            12'hFF4: return {m_flag, 13'b0, m_ar, m_en};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_gpio = 0; m_cnt = 0; m_cmp = 0;
        m_en = 0; m_ar = 0; m_flag = 0;
        pin_hist = '{16'h0, 16'h0};
    endtask

    task automatic model_edge(input logic wm, input logic [11:0] a, input logic [15:0] d);
        logic        match;
        logic [15:0] next_cnt;
        logic        next_flag;
        match     = m_en && (m_cnt == m_cmp);
        next_cnt  = m_cnt;
        if (m_en) next_cnt = (match && m_ar) ? 16'h0000 : m_cnt + 16'd1;
        next_flag = m_flag;
        pin_hist.push_front(gpio_in);
        void'(pin_hist.pop_back());
        if (wm) begin
            if (a < 12'hFF0) ram_m[int'(a)] = d;
            else if (a == 12'hFF0) m_gpio = d;
            else if (a == 12'hFF2) next_cnt = d;
            else if (a == 12'hFF3) m_cmp = d;
            else if (a == 12'hFF4) begin
                m_en = d[0];
                m_ar = d[1];
                if (d[15]) next_flag = 1'b0;
            end
        end
        if (match) next_flag = 1'b1;
        m_cnt  = next_cnt;
        m_flag = next_flag;
    endtask

    // One bus cycle: drive at negedge, sample 1ns later, commit model at posedge.
    task automatic do_cycle(input logic wm, input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        mif.Memory_addressbus = a;
        mif.Memory_writemode  = wm;
        drv_en  = wm;
        drv_dat = d;
        gpio_in = pin_drive;
        #1;
        ob = dbus;
        eb = wm ? d : model_read(a);
        og = gpio_out;  eg = m_gpio;
        oi = timer_irq; ei = m_flag;
        @(posedge clk);
        model_edge(wm, a, d);
    endtask

    task automatic test_reset();
        if (gpio_out !== 16'h0000 || timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got gpio=%h irq=%b expected 0000/0", gpio_out, timer_irq);
        end
        checks++;
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 12'hFF0 + 12'(i), 16'h0);
            checks++;
            if (ob !== 16'h0000) begin
                errors++;
                $display("FAIL reset_mmio_%0d: got %h expected 0000", i, ob);
            end
        end
    endtask

    task automatic test_ram();
        logic [11:0] addrs [$];
        logic [11:0] a;
        do_cycle(1'b1, 12'h005, 16'h1234);
        checks++;
        if (ob !== 16'h1234) begin errors++; $display("FAIL ram_hiz_wr1: got %h expected 1234", ob); end
        do_cycle(1'b1, 12'hFEF, 16'hBEEF);
        checks++;
        if (ob !== 16'hBEEF) begin errors++; $display("FAIL ram_hiz_wr2: got %h expected beef", ob); end
        do_cycle(1'b0, 12'h005, 16'h0);
        checks++;
        if (ob !== 16'h1234) begin errors++; $display("FAIL ram_rd_005: got %h expected 1234", ob); end
        do_cycle(1'b0, 12'hFEF, 16'h0);
        checks++;
        if (ob !== 16'hBEEF) begin errors++; $display("FAIL ram_rd_fef: got %h expected beef", ob); end
        for (int i = 0; i < 16; i++) begin
            a = 12'($urandom_range(0, 12'hFEF));
            addrs.push_back(a);
            do_cycle(1'b1, a, 16'($urandom));
            // read-after-write in the very next cycle
            do_cycle(1'b0, a, 16'h0);
            checks++;
            if (ob !== eb) begin errors++; $display("FAIL ram_raw @%h: got %h expected %h", a, ob, eb); end
        end
        addrs.shuffle();
        foreach (addrs[i]) begin
            do_cycle(1'b0, addrs[i], 16'h0);
            checks++;
            if (ob !== eb) begin errors++; $display("FAIL ram_rand @%h: got %h expected %h", addrs[i], ob, eb); end
        end
    endtask

    task automatic test_gpio();
        do_cycle(1'b1, 12'hFF0, 16'h00A5);
        do_cycle(1'b0, 12'hFF0, 16'h0);
        checks++;
        if (og !== 16'h00A5 || ob !== 16'h00A5) begin
            errors++; $display("FAIL gpio_out: got pin=%h rd=%h expected 00a5", og, ob);
        end
        pin_drive = 16'h5A5A;
        do_cycle(1'b0, 12'hFF1, 16'h0);
        do_cycle(1'b0, 12'hFF1, 16'h0);
        checks++;
        if (ob !== 16'h0000) begin errors++; $display("FAIL gpio_in_edge1: got %h expected 0000", ob); end
        do_cycle(1'b0, 12'hFF1, 16'h0);
        checks++;
        if (ob !== 16'h5A5A) begin errors++; $display("FAIL gpio_in_edge2: got %h expected 5a5a", ob); end
        do_cycle(1'b1, 12'hFF1, 16'hFFFF);
        do_cycle(1'b0, 12'hFF1, 16'h0);
        checks++;
        if (ob !== 16'h5A5A) begin errors++; $display("FAIL gpio_in_ro: got %h expected 5a5a", ob); end
        do_cycle(1'b1, 12'hFF5, 16'h1234);
        do_cycle(1'b1, 12'hFFF, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            logic [11:0] a;
            a = (i == 0) ? 12'hFF5 : (i == 1) ? 12'hFF8 : 12'hFFF;
            do_cycle(1'b0, a, 16'h0);
            checks++;
            if (ob !== 16'h0000) begin errors++; $display("FAIL mmio_unused @%h: got %h expected 0000", a, ob); end
        end
        checks++;
        if (og !== 16'h00A5) begin errors++; $display("FAIL gpio_hold: got %h expected 00a5", og); end
    endtask

    task automatic test_timer();
        int rise;
        rise = -1;
        do_cycle(1'b1, 12'hFF4, 16'h8000);
        do_cycle(1'b1, 12'hFF3, 16'h0005);
        do_cycle(1'b1, 12'hFF2, 16'h0000);
        do_cycle(1'b1, 12'hFF4, 16'h0001);
        for (int k = 0; k <= 10; k++) begin
            do_cycle(1'b0, 12'hFF2, 16'h0);
            checks++;
            if (ob !== 16'(k)) begin errors++; $display("FAIL timer_count k=%0d: got %h expected %h", k, ob, 16'(k)); end
            if (oi && rise < 0) rise = k;
        end
        checks++;
        if (rise != 6) begin errors++; $display("FAIL timer_irq_rise: got %0d expected 6", rise); end
        do_cycle(1'b1, 12'hFF4, 16'h8001);
        do_cycle(1'b0, 12'hFF4, 16'h0);
        checks++;
        if (oi !== 1'b0 || ob !== 16'h0001) begin
            errors++; $display("FAIL timer_w1c: got irq=%b sts=%h expected 0/0001", oi, ob);
        end
    endtask

    task automatic test_autoreload();
        do_cycle(1'b1, 12'hFF4, 16'h8000);
        do_cycle(1'b1, 12'hFF2, 16'h0000);
        do_cycle(1'b1, 12'hFF3, 16'h0003);
        do_cycle(1'b1, 12'hFF4, 16'h0003);
        for (int k = 0; k < 10; k++) begin
            do_cycle(1'b0, 12'hFF2, 16'h0);
            checks++;
            if (ob !== 16'(k % 4) || oi !== (k >= 4)) begin
                errors++; $display("FAIL autoreload k=%0d: got cnt=%h irq=%b expected %h/%b", k, ob, oi, 16'(k % 4), (k >= 4));
            end
        end
        do_cycle(1'b1, 12'hFF4, 16'h8000);
        do_cycle(1'b1, 12'hFF3, 16'h0010);
        do_cycle(1'b1, 12'hFF2, 16'hFFFE);
        do_cycle(1'b1, 12'hFF4, 16'h0001);
        for (int k = 0; k < 4; k++) begin
            do_cycle(1'b0, 12'hFF2, 16'h0);
            checks++;
            if (ob !== 16'hFFFE + 16'(k)) begin
                errors++; $display("FAIL timer_wrap k=%0d: got %h expected %h", k, ob, 16'hFFFE + 16'(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_cycle(1'b1, 12'hFF2, 16'h0100);
        do_cycle(1'b0, 12'hFF2, 16'h0);
        checks++;
        if (ob !== 16'h0100) begin errors++; $display("FAIL cnt_write_wins: got %h expected 0100", ob); end
        do_cycle(1'b0, 12'hFF2, 16'h0);
        checks++;
        if (ob !== 16'h0101) begin errors++; $display("FAIL cnt_after_write: got %h expected 0101", ob); end
        do_cycle(1'b1, 12'hFF4, 16'h8000);
        do_cycle(1'b1, 12'hFF2, 16'h0020);
        do_cycle(1'b1, 12'hFF3, 16'h0022);
        do_cycle(1'b1, 12'hFF4, 16'h0001);
        do_cycle(1'b0, 12'hFF2, 16'h0);
        do_cycle(1'b0, 12'hFF2, 16'h0);
        do_cycle(1'b1, 12'hFF4, 16'h8001);
        do_cycle(1'b0, 12'hFF4, 16'h0);
        checks++;
        if (ob !== 16'h8001 || oi !== 1'b1) begin
            errors++; $display("FAIL set_beats_clear: got sts=%h irq=%b expected 8001/1", ob, oi);
        end
    endtask

    task automatic test_random();
        logic [11:0] pool [8];
        logic [11:0] a;
        logic [15:0] d;
        logic        wm;
        for (int i = 0; i < 8; i++) begin
            pool[i] = 12'h100 + 12'(i * 37);
            do_cycle(1'b1, pool[i], 16'($urandom));
        end
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) pin_drive = 16'($urandom);
            wm = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : 12'hFF0 + 12'($urandom_range(0, 15));
            d  = 16'($urandom);
            if (a == 12'hFF2 || a == 12'hFF3) d = 16'($urandom_range(0, 40));
            do_cycle(wm, a, d);
            checks++;
            if (ob !== eb || og !== eg || oi !== ei) begin
                errors++;
                $display("FAIL random n=%0d a=%h wm=%b: got bus=%h gpio=%h irq=%b expected %h/%h/%b", n, a, wm, ob, og, oi, eb, eg, ei);
            end
        end
    endtask

    task automatic test_async_reset();
        do_cycle(1'b1, 12'hFF0, 16'hFFFF);
        do_cycle(1'b1, 12'hFF4, 16'h8000);
        do_cycle(1'b1, 12'hFF2, 16'h0000);
        do_cycle(1'b1, 12'hFF3, 16'h0002);
        do_cycle(1'b1, 12'hFF4, 16'h0001);
        for (int k = 0; k < 4; k++) do_cycle(1'b0, 12'hFF2, 16'h0);
        checks++;
        if (timer_irq !== 1'b1 || gpio_out !== 16'hFFFF) begin
            errors++; $display("FAIL prereset_state: got irq=%b gpio=%h expected 1/ffff", timer_irq, gpio_out);
        end
        @(negedge clk);
        mif.Memory_addressbus = 12'h005;
        mif.Memory_writemode  = 1'b0;
        drv_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gpio_out !== 16'h0000 || timer_irq !== 1'b0) begin
            errors++; $display("FAIL async_reset: got gpio=%h irq=%b expected 0000/0", gpio_out, timer_irq);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 12'h005, 16'h0);
        do_cycle(1'b0, 12'h005, 16'h0);
        checks++;
        if (ob !== eb) begin errors++; $display("FAIL ram_survives_reset: got %h expected %h", ob, eb); end
        do_cycle(1'b0, 12'hFF4, 16'h0);
        checks++;
        if (ob !== 16'h0000) begin errors++; $display("FAIL sts_after_reset: got %h expected 0000", ob); end
        do_cycle(1'b0, 12'hFF2, 16'h0);
        checks++;
        if (ob !== 16'h0000) begin errors++; $display("FAIL cnt_after_reset: got %h expected 0000", ob); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mif.Memory_addressbus = 12'h000;
        mif.Memory_writemode  = 1'b0;
        drv_en    = 1'b0;
        drv_dat   = 16'h0;
        pin_drive = 16'h0;
        gpio_in   = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 12'h000, 16'h0);

        test_reset();
        test_ram();
        test_gpio();
        test_timer();
        test_autoreload();
        test_back_to_back();
        test_random();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
